// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative HI/LO multiply/divide unit. Executes MULT, MULTU,
//                DIV and DIVU in 33 cycles (32 radix-2 iterations plus a
//                sign-fix cycle) and single-cycle MTHI/MTLO. Owns the
//                architectural HI and LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    localparam logic [1:0] c_ROP_MULT = 2'd0;
    localparam logic [1:0] c_ROP_DIV  = 2'd2;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_busy_next;
    logic        w_done_next;

    logic [1:0]  r_op;        // latched arithmetic op (0..3)
    logic [31:0] r_opa;       // multiplicand magnitude (multiply)
    logic [31:0] r_opb;       // divisor magnitude (divide)
    logic [63:0] r_acc;       // working accumulator
    logic [5:0]  r_cnt;       // iteration counter
    logic        r_neg_q;     // operand signs differ
    logic        r_neg_r;     // dividend was negative
    logic        r_divz;      // divisor was zero
    logic [31:0] r_a_raw;     // original dividend, returned in HI on divide by zero
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    // Operand conditioning at start: magnitudes for signed ops, raw otherwise
    logic        w_signed_op;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    assign w_signed_op = ~op[0];
    assign w_a_neg     = w_signed_op & a[31];
    assign w_b_neg     = w_signed_op & b[31];
    assign w_a_mag     = w_a_neg ? (32'd0 - a) : a;
    assign w_b_mag     = w_b_neg ? (32'd0 - b) : b;

    // Multiply step: add multiplicand into upper half when LSB set, shift right
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_opa};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[31:1]}
                                 : {1'b0, r_acc[63:1]};

    // Restoring divide step: shift remainder:dividend left, subtract if it fits.
    // The partial remainder is always below the divisor, so the difference
    // fits in 32 bits whenever the subtraction succeeds.
    logic [32:0] w_rem_sh;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_div_next;

    assign w_rem_sh   = r_acc[63:31];
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_opb});
    assign w_div_diff = w_rem_sh[31:0] - r_opb;
    assign w_div_next = w_div_ge ? {w_div_diff, r_acc[30:0], 1'b1}
                                 : {r_acc[62:0], 1'b0};

    // Final sign correction and HI/LO selection in FIX
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_prod = ((r_op == c_ROP_MULT) && r_neg_q) ? (64'd0 - r_acc) : r_acc;
    assign w_quo  = ((r_op == c_ROP_DIV) && r_neg_q) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = ((r_op == c_ROP_DIV) && r_neg_r) ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    assign w_res_hi = r_op[1] ? (r_divz ? r_a_raw : w_rem) : w_prod[63:32];
    assign w_res_lo = r_op[1] ? (r_divz ? 32'hFFFF_FFFF : w_quo) : w_prod[31:0];

    // Next-state and registered-output decode
    always_comb begin
        w_state_next = r_state;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !op[2]) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_LAST_ITER) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_next = ST_IDLE;
                w_done_next  = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_busy_next = (w_state_next != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch, iteration datapath and HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= 2'd0;
            r_opa   <= 32'd0;
            r_opb   <= 32'd0;
            r_acc   <= 64'd0;
            r_cnt   <= 6'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_divz  <= 1'b0;
            r_a_raw <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_done_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
                                r_op    <= op[1:0];
                                r_opa   <= w_a_mag;
                                r_opb   <= w_b_mag;
                                r_neg_q <= w_a_neg ^ w_b_neg;
                                r_neg_r <= w_a_neg;
                                r_divz  <= (b == 32'd0);
                                r_a_raw <= a;
                                r_cnt   <= 6'd0;
                                // Multiply shifts the multiplier out of the low half;
                                // divide shifts the dividend out of the low half.
                                r_acc   <= op[1] ? {32'd0, w_a_mag} : {32'd0, w_b_mag};
                            end
                            c_OP_MTHI: r_hi <= a;
                            c_OP_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                end
                ST_FIX: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit using a reference
//                model and a scoreboard queue of expected HI/LO results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Architectural reference: {hi, lo} for an arithmetic op
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic [31:0] q;
        logic [31:0] r;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            3'd1: return {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = x / y;
                r = x % y;
                return {r, q};
            end
            default: return {m_hi, m_lo};
        endcase
    endfunction

    // Issue one arithmetic op, optionally pulsing MTHI a=7 at busy-sample inject_at
    task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb, input int inject_at);
        int n;
        logic [63:0] exp;
        sb_q.push_back(ref_model(o, xa, xb));
        start = 1'b1; op = o; a = xa; b = xb;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            checks++;
            if (hi !== m_hi || lo !== m_lo || done !== 1'b0) begin
                errors++;
                $display("FAIL hold_during_run cyc=%0d hi=%h lo=%h done=%b expected hi=%h lo=%h done=0",
                         n, hi, lo, done, m_hi, m_lo);
            end
            if (n == inject_at) begin
                start = 1'b1; op = 3'd4; a = 32'd7;
            end else begin
                start = 1'b0; op = 3'd0; a = 32'd0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL busy_cycles got=%0d expected=33", n);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse got=%b expected=1", done);
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=0 entries expected=1");
        end else begin
            exp = sb_q.pop_front();
            if ({hi, lo} !== exp) begin
                errors++;
                $display("FAIL result op=%0d a=%h b=%h got hi=%h lo=%h expected hi=%h lo=%h",
                         o, xa, xb, hi, lo, exp[63:32], exp[31:0]);
            end
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state hi=%h lo=%h busy=%b done=%b expected all zero", hi, lo, busy, done);
        end
    endtask

    task automatic test_mult();
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL mult_neg3x5 got hi=%h lo=%h expected hi=ffffffff lo=fffffff1", hi, lo);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle got=%b expected=0", done);
        end
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max got hi=%h lo=%h expected hi=fffffffe lo=00000001", hi, lo);
        end
    endtask

    task automatic test_div();
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_neg7_2 got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", hi, lo);
        end
        run_op(3'd3, 32'd100, 32'd0, 0);
        checks++;
        if (hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divu_by_zero got hi=%h lo=%h expected hi=00000064 lo=ffffffff", hi, lo);
        end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_overflow got hi=%h lo=%h expected hi=00000000 lo=80000000", hi, lo);
        end
        run_op(3'd2, 32'hFFFF_FFF6, 32'd0, 0);
        checks++;
        if (hi !== 32'hFFFF_FFF6 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_by_zero_signed got hi=%h lo=%h expected hi=fffffff6 lo=ffffffff", hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        @(posedge clk); #1;
        start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        m_hi = 32'hDEAD_BEEF;
        checks++;
        if (hi !== 32'hDEAD_BEEF || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mthi got hi=%h busy=%b done=%b expected hi=deadbeef busy=0 done=0", hi, busy, done);
        end
        op = 3'd5; a = 32'h1234_5678;
        @(posedge clk); #1;
        m_lo = 32'h1234_5678;
        checks++;
        if (hi !== 32'hDEAD_BEEF || lo !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b expected hi=deadbeef lo=12345678 busy=0 done=0",
                     hi, lo, busy, done);
        end
        op = 3'd6; a = 32'hFFFF_FFFF; b = 32'd1;
        @(posedge clk); #1;
        op = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reserved_op got hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=0 done=0",
                     hi, lo, busy, done, m_hi, m_lo);
        end
    endtask

    task automatic test_start_ignored();
        start = 1'b1; op = 3'd4; a = 32'd1;
        @(posedge clk); #1;
        op = 3'd5; a = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        m_hi = 32'd1; m_lo = 32'd2;
        checks++;
        if (hi !== 32'd1 || lo !== 32'd2) begin
            errors++;
            $display("FAIL preload got hi=%h lo=%h expected hi=1 lo=2", hi, lo);
        end
        run_op(3'd0, 32'd6, 32'hFFFF_FFF9, 6);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFD6) begin
            errors++;
            $display("FAIL mult_with_ignored_mthi got hi=%h lo=%h expected hi=ffffffff lo=ffffffd6", hi, lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun got hi=%h lo=%h busy=%b done=%b expected all zero", hi, lo, busy, done);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun_idle got hi=%h lo=%h busy=%b done=%b expected all zero", hi, lo, busy, done);
        end
        run_op(3'd3, 32'd1000, 32'd3, 0);
        checks++;
        if (hi !== 32'd1 || lo !== 32'd333) begin
            errors++;
            $display("FAIL divu_after_reset got hi=%h lo=%h expected hi=1 lo=333", hi, lo);
        end
    endtask

    // Consecutive ops, each issued on the cycle its predecessor reports done
    task automatic test_back_to_back();
        logic [31:0] xa;
        logic [31:0] xb;
        logic [2:0]  o;
        for (int i = 0; i < 10; i++) begin
            o  = 3'($urandom_range(0, 3));
            xa = $urandom;
            xb = (i % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
            if (i % 3 == 1) xb = xb >> $urandom_range(0, 31);
            run_op(o, xa, xb, 0);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_idle got done=%b busy=%b expected done=0 busy=0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
